// File: rtl/alu_pkg.sv
// Shared types for the ALU issue controller: opcode width, FSM states and
// the command layout used by the queue and the 4-bit ALU attached to it.
package alu_pkg;
  localparam int OP_W  = 3;
  localparam int ALU_W = 4;

  typedef logic [OP_W-1:0] op_t;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  // Fixed-width view of one command as it sits in the queue ({a, b, sel}).
  typedef struct packed {
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
    op_t              sel;
  } alu_cmd_t;
endpackage

// File: rtl/alu_cmd_fifo.sv
// Command queue: DEPTH entries of EW bits, pointers carry an extra wrap bit
// so full and empty are told apart without a separate counter.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int EW    = 11
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [EW-1:0]            wdata,
  input  logic                     pop,
  output logic [EW-1:0]            rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          do_push, do_pop;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];
  // Guarded here as well so a stray push/pop can never corrupt the pointers.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues queued commands to an external combinational ALU one at a time and
// holds each result until downstream accepts it (IDLE -> ISSUE -> HOLD).
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [W-1:0]             cmd_a,
  input  logic [W-1:0]             cmd_b,
  input  logic [OP_W-1:0]          cmd_sel,
  output logic [W-1:0]             alu_a,
  output logic [W-1:0]             alu_b,
  output logic [OP_W-1:0]          alu_sel,
  input  logic [W-1:0]             alu_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [W-1:0]             res_data,
  output logic [OP_W-1:0]          res_sel,
  output logic                     res_zero,
  output logic [$clog2(DEPTH):0]   cmd_count
);
  localparam int EW = 2*W + OP_W;

  state_t          state_q, state_d;
  logic [W-1:0]    alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  op_t             alu_sel_q, alu_sel_d;
  logic            res_valid_q, res_valid_d;
  logic [W-1:0]    res_data_q, res_data_d;
  op_t             res_sel_q, res_sel_d;
  logic            res_zero_q, res_zero_d;

  logic [EW-1:0]   head;
  logic            fifo_full, fifo_empty, pop;

  alu_cmd_fifo #(.DEPTH(DEPTH), .EW(EW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_valid),
    .wdata ({cmd_a, cmd_b, cmd_sel}),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (cmd_count)
  );

  // Ready comes straight from the pointer flops; a pop in the same cycle
  // does not free a slot early.
  assign cmd_ready = !fifo_full;
  assign pop       = (state_q == IDLE) && !fifo_empty;

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_sel_d   = res_sel_q;
    res_zero_d  = res_zero_q;
    case (state_q)
      IDLE: if (!fifo_empty) begin
        alu_a_d   = head[EW-1 -: W];
        alu_b_d   = head[OP_W +: W];
        alu_sel_d = head[OP_W-1:0];
        state_d   = ISSUE;
      end
      // The ALU has had a whole cycle on the registered operands by now.
      ISSUE: begin
        res_data_d  = alu_out;
        res_sel_d   = alu_sel_q;
        res_zero_d  = (alu_out == '0);
        res_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: if (res_ready) begin
        res_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_sel_q   <= '0;
      res_zero_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_sel_q   <= res_sel_d;
      res_zero_q  <= res_zero_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_sel   = res_sel_q;
  assign res_zero  = res_zero_q;
endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 The parameter list SHALL be: DEPTH, default 4, command FIFO entries (power of 2, 2..16).
REQ-002 The parameter list SHALL also include: W, default 4, operand/result width.
REQ-003 Port clk SHALL be an input, 1 bit: the single clock; all state SHALL be on its rising edge.
REQ-004 Port rst_n SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-005 Port cmd_valid SHALL be an input, 1 bit: upstream command present.
REQ-006 Port cmd_ready SHALL be an output, 1 bit: FIFO can accept a command.
REQ-007 Port cmd_a SHALL be an input, W bits: operand A.
REQ-008 Port cmd_b SHALL be an input, W bits: operand B.
REQ-009 Port cmd_sel SHALL be an input, 3 bits: ALU opcode.
REQ-010 Ports alu_a and alu_b SHALL be outputs, W bits each: registered operands to the ALU.
REQ-011 Port alu_sel SHALL be an output, 3 bits: registered opcode to the ALU.
REQ-012 Port alu_out SHALL be an input, W bits: combinational ALU result.
REQ-013 Port res_valid SHALL be an output, 1 bit: result held for downstream.
REQ-014 Port res_ready SHALL be an input, 1 bit: downstream accepts the result.
REQ-015 Port res_data SHALL be an output, W bits: captured result.
REQ-016 Port res_sel SHALL be an output, 3 bits: opcode that produced res_data.
REQ-017 Port res_zero SHALL be an output, 1 bit: res_data == 0.
REQ-018 Port cmd_count SHALL be an output, $clog2(DEPTH)+1 bits: FIFO occupancy.

Function
REQ-019 A command SHALL be pushed on an edge where cmd_valid && cmd_ready.
REQ-020 cmd_ready SHALL equal !full and SHALL depend only on registered state, not on any same-cycle pop.
REQ-021 The FSM SHALL have the states IDLE, ISSUE and HOLD.
REQ-022 In IDLE with the FIFO not empty, the block SHALL pop the head entry, load alu_a/alu_b/alu_sel, and go to ISSUE.
REQ-023 In IDLE with the FIFO empty, the FSM SHALL stay in IDLE.
REQ-024 In ISSUE, the block SHALL capture alu_out into res_data, alu_sel into res_sel, set res_valid=1 and go to HOLD; the state lasts exactly one cycle, which gives the ALU a full cycle to settle.
REQ-025 In HOLD, res_data, res_sel, res_zero and res_valid SHALL stay stable until res_valid && res_ready.
REQ-026 On the handshake edge in HOLD, the block SHALL clear res_valid and go to IDLE.
REQ-027 The next pop after a HOLD exit SHALL occur no earlier than the following edge, giving a maximum throughput of one result per 3 cycles.
REQ-028 Latency: a command pushed at edge k into an empty FIFO with the FSM in IDLE SHALL give res_valid=1 after edge k+2.
REQ-029 alu_a/alu_b/alu_sel SHALL hold their last issued values outside ISSUE.
REQ-030 Simultaneous push and pop SHALL both take effect, leaving cmd_count unchanged.
REQ-031 A push when full SHALL be impossible because cmd_ready=0; cmd_valid is ignored in that case.
REQ-032 FIFO pointers SHALL wrap modulo DEPTH, using an extra MSB for the full/empty distinction.
REQ-033 res_zero SHALL be registered together with res_data.
REQ-034 No arithmetic SHALL be performed on the operands; data SHALL pass through unmodified at width W.

Reset
REQ-035 rst_n low SHALL immediately, without a clock, set: FSM=IDLE, FIFO empty, cmd_count=0, cmd_ready=1.
REQ-036 rst_n low SHALL also immediately set: res_valid=0, res_data=0, res_sel=0, res_zero=1, alu_a=0, alu_b=0, alu_sel=0.
REQ-037 Reset asserted in ISSUE or HOLD SHALL discard the in-flight result and all queued commands.
REQ-038 rst_n deassertion SHALL take effect on the next clk edge; the first push SHALL be possible on that edge.

Structure
REQ-039 A shared package alu_pkg SHALL hold the opcode width constant (3), the state enum (IDLE/ISSUE/HOLD), and the command struct {a, b, sel}.
REQ-040 One sub-module, alu_cmd_fifo (parameterised DEPTH and entry width, same clk/rst_n), SHALL hold the command queue.
REQ-041 The FSM and result registers SHALL reside in alu_issue_ctrl.
REQ-042 The bench SHALL connect the existing 4-bit ALU to alu_a/alu_b/alu_sel/alu_out and SHALL check res_data against a behavioural model of that ALU.

Verification
REQ-043 Single command: push a=0011, b=0001, sel=000 at edge k into an idle block; the bench SHALL see res_valid=1 after edge k+2, with res_data=model(3,1,000) and res_sel=000.
REQ-044 Back-pressure: hold res_ready=0 for 5 cycles with a result pending; res_data/res_sel SHALL stay stable, the FIFO SHALL keep accepting commands, and the next pop SHALL happen only after the handshake.
REQ-045 Fill: push 5 commands back-to-back with res_ready=0 and DEPTH=4; the first SHALL issue, 4 SHALL queue, cmd_ready SHALL drop to 0 and cmd_count SHALL be 4.
REQ-046 Drain: with res_ready=1, all results SHALL arrive in push order, one every 3 cycles.
REQ-047 Zero flag: push a=0011, b=0011 with an opcode whose model result is 0000; the bench SHALL see res_zero=1.
REQ-048 Reset mid-operation: assert rst_n=0 in HOLD with 3 commands queued; all outputs SHALL take their reset values immediately, and after release no stale result SHALL appear.
